// File: rtl/bus_arbiter_rr8.sv
// bus_arbiter_rr8: round-robin arbiter granting one single-transaction
// resource to one of eight requesters. The grant is held from launch until
// the resource reports completion, or until the watchdog gives up on it.
// The grant is presented both one-hot and as a binary index.
module bus_arbiter_rr8 #(
  parameter int unsigned TIMEOUT = 255  // max BUSY cycles without done; 0 disables
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       start,
  output logic       timeout_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam bit          WDOG_EN  = (TIMEOUT != 0);
  // Last count value of a transaction; only used when the watchdog is enabled.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  gnt_q, gnt_d;
  logic [2:0]  gnt_idx_q, gnt_idx_d;
  logic        start_q, start_d;
  logic        timeout_err_q, timeout_err_d;

  logic        pick_valid;
  logic [2:0]  pick_idx;
  logic [2:0]  cand;
  logic        wdog_fire;

  // Round-robin pick: scan ptr, ptr+1, ... modulo 8. The loop runs from the
  // farthest offset to the nearest so the nearest set bit is written last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    pick_valid = 1'b0;
    pick_idx   = 3'd0;
    cand       = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign wdog_fire = WDOG_EN && (cnt_q == CNT_LAST);

  // State register; reset may land at any time, including mid-transaction.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: grant on any request in IDLE, release on done or watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pick_valid) state_d = S_BUSY;
      S_BUSY: if (done || wdog_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: grant capture, release, pointer advance, watchdog.
  always_comb begin
    gnt_d         = gnt_q;
    gnt_idx_d     = gnt_idx_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    start_d       = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done in IDLE is deliberately not looked at.
        if (pick_valid) begin
          gnt_idx_d = pick_idx;
          gnt_d     = 8'h01 << pick_idx;
          start_d   = 1'b1;
          cnt_d     = 16'd0;
        end
      end
      S_BUSY: begin
        // done takes precedence over a simultaneous watchdog expiry.
        if (done || wdog_fire) begin
          gnt_d         = 8'h00;
          gnt_idx_d     = 3'd0;
          ptr_d         = gnt_idx_q + 3'd1;
          timeout_err_d = !done;
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        gnt_d     = 8'h00;
        gnt_idx_d = 3'd0;
      end
    endcase
  end

  // Registered outputs and internal registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q         <= 8'h00;
      gnt_idx_q     <= 3'd0;
      ptr_q         <= 3'd0;
      cnt_q         <= 16'd0;
      start_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      gnt_q         <= gnt_d;
      gnt_idx_q     <= gnt_idx_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      start_q       <= start_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = gnt_idx_q;
  assign busy        = (state_q == S_BUSY);
  assign start       = start_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter_rr8.sv
// tb_bus_arbiter_rr8: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the round-robin arbiter.
module tb_bus_arbiter_rr8;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       start;
  logic       timeout_err;
  logic [13:0] dut_out;

  int checks   = 0;
  int failures = 0;

  bus_arbiter_rr8 #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .busy        (busy),
    .start       (start),
    .timeout_err (timeout_err)
  );

  assign dut_out = {gnt, gnt_idx, busy, start, timeout_err};

  always #5 clk = ~clk;

  // Behavioural model: owner index, priority pointer, busy-cycle count.
  int m_ptr;
  int m_idx;
  int m_cyc;
  bit m_busy;
  bit m_start;
  bit m_terr;

  task automatic model_reset();
    m_ptr = 0; m_idx = 0; m_cyc = 0;
    m_busy = 1'b0; m_start = 1'b0; m_terr = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    bit found;
    m_start = 1'b0;
    m_terr  = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int off = 0; off < 8; off++) begin
        int i;
        i = (m_ptr + off) % 8;
        if (!found && r[i]) begin
          found = 1'b1;
          m_idx = i;
        end
      end
      if (found) begin
        m_busy = 1'b1; m_start = 1'b1; m_cyc = 1;
      end
    end else if (d) begin
      m_busy = 1'b0; m_ptr = (m_idx + 1) % 8; m_idx = 0;
    end else if (TO != 0 && m_cyc == int'(TO)) begin
      m_busy = 1'b0; m_ptr = (m_idx + 1) % 8; m_idx = 0; m_terr = 1'b1;
    end else begin
      m_cyc++;
    end
  endtask

  function automatic logic [13:0] exp_out();
    logic [7:0] g;
    g = m_busy ? (8'h01 << m_idx) : 8'h00;
    return {g, 3'(m_idx), m_busy, m_start, m_terr};
  endfunction

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (dut_out !== 14'h0) begin
      failures++; $display("FAIL reset_idle got=%h want=0000", dut_out);
    end
    step(8'h20, 1'b0);
    checks++;
    if (gnt_idx !== 3'd5 || gnt !== 8'h20 || busy !== 1'b1) begin
      failures++; $display("FAIL reset_first_grant gnt=%h idx=%0d busy=%b want gnt=20 idx=5 busy=1", gnt, gnt_idx, busy);
    end
    step(8'h20, 1'b0);
    // asynchronous reset mid-BUSY, away from any clock edge
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_out !== 14'h0) begin
      failures++; $display("FAIL reset_async got=%h want=0000", dut_out);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut_out !== 14'h0) begin
      failures++; $display("FAIL reset_hold got=%h want=0000", dut_out);
    end
    rst = 1'b0;
    step(8'h20, 1'b0);
    checks++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5 || start !== 1'b1) begin
      failures++; $display("FAIL reset_regrant gnt=%h idx=%0d start=%b want gnt=20 idx=5 start=1", gnt, gnt_idx, start);
    end
    step(8'h00, 1'b1);
    checks++;
    if (dut_out !== exp_out()) begin
      failures++; $display("FAIL reset_release got=%h want=%h", dut_out, exp_out());
    end
  endtask

  task automatic test_single();
    int busy_n;
    step(8'h08, 1'b0);
    checks++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3 || busy !== 1'b1 || start !== 1'b1) begin
      failures++; $display("FAIL single_grant gnt=%h idx=%0d busy=%b start=%b want 08/3/1/1", gnt, gnt_idx, busy, start);
    end
    busy_n = 1;
    for (int i = 0; i < 3; i++) begin
      step(8'h08, 1'b0);
      checks++;
      if (dut_out !== exp_out() || start !== 1'b0) begin
        failures++; $display("FAIL single_hold cyc=%0d got=%h want=%h", i, dut_out, exp_out());
      end
      if (busy) busy_n++;
    end
    // done on the 4th BUSY cycle coincides with watchdog expiry: done wins
    step(8'h00, 1'b1);
    checks++;
    if (busy !== 1'b0 || gnt !== 8'h00 || timeout_err !== 1'b0 || busy_n != 4) begin
      failures++; $display("FAIL single_release busy=%b gnt=%h terr=%b busy_cycles=%0d want 0/00/0/4", busy, gnt, timeout_err, busy_n);
    end
    step(8'hFF, 1'b0);
    checks++;
    if (gnt_idx !== 3'd4) begin
      failures++; $display("FAIL single_ptr idx=%0d want 4", gnt_idx);
    end
    step(8'h00, 1'b1);
  endtask

  task automatic test_rotation();
    time t0;
    apply_reset();
    t0 = 0;
    for (int n = 0; n < 9; n++) begin
      step(8'hFF, 1'b0);
      checks++;
      if (gnt_idx !== 3'(n % 8) || start !== 1'b1 || dut_out !== exp_out()) begin
        failures++; $display("FAIL rotation_grant n=%0d idx=%0d start=%b want idx=%0d start=1", n, gnt_idx, start, n % 8);
      end
      if (n == 0) t0 = $time;
      if (n == 8) begin
        checks++;
        if ($time - t0 != 160) begin
          failures++; $display("FAIL rotation_period got=%0t want=160", $time - t0);
        end
      end
      step(8'hFF, 1'b1);
      checks++;
      if (busy !== 1'b0 || dut_out !== exp_out()) begin
        failures++; $display("FAIL rotation_release n=%0d got=%h want=%h", n, dut_out, exp_out());
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(8'h40, 1'b0);
    step(8'h00, 1'b1);
    step(8'h81, 1'b0);
    checks++;
    if (gnt_idx !== 3'd7 || gnt !== 8'h80) begin
      failures++; $display("FAIL wrap_seven gnt=%h idx=%0d want 80/7", gnt, gnt_idx);
    end
    step(8'h00, 1'b1);
    step(8'h81, 1'b0);
    checks++;
    if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
      failures++; $display("FAIL wrap_zero gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
    end
    step(8'h00, 1'b1);
  endtask

  task automatic test_watchdog();
    int busy_n;
    bit released;
    apply_reset();
    step(8'h02, 1'b0);
    busy_n   = 1;
    released = 1'b0;
    for (int i = 0; i < 20 && !released; i++) begin
      step(8'h00, 1'b0);
      checks++;
      if (dut_out !== exp_out()) begin
        failures++; $display("FAIL wd_model cyc=%0d got=%h want=%h", i, dut_out, exp_out());
      end
      if (!busy) begin
        released = 1'b1;
        checks++;
        if (timeout_err !== 1'b1 || busy_n != 4) begin
          failures++; $display("FAIL wd_abort terr=%b busy_cycles=%0d want 1/4", timeout_err, busy_n);
        end
      end else begin
        busy_n++;
      end
    end
    checks++;
    if (!released) begin
      failures++; $display("FAIL wd_bound busy_cycles=%0d want release within 20", busy_n);
    end
    step(8'h00, 1'b0);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++; $display("FAIL wd_pulse_width terr=%b want 0", timeout_err);
    end
    step(8'hFF, 1'b0);
    checks++;
    if (gnt_idx !== 3'd2) begin
      failures++; $display("FAIL wd_ptr idx=%0d want 2", gnt_idx);
    end
    step(8'h00, 1'b1);
    // done on the 4th BUSY cycle: no abort
    step(8'h02, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 || dut_out !== exp_out()) begin
      failures++; $display("FAIL wd_done_wins terr=%b busy=%b want 0/0", timeout_err, busy);
    end
    step(8'h00, 1'b0);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++; $display("FAIL wd_no_late_err terr=%b want 0", timeout_err);
    end
  endtask

  task automatic test_hold_stray();
    apply_reset();
    step(8'h04, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'h02, 1'b0);
      checks++;
      if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
        failures++; $display("FAIL hold_grant cyc=%0d gnt=%h idx=%0d want 04/2", i, gnt, gnt_idx);
      end
    end
    step(8'h02, 1'b1);
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b0) begin
      failures++; $display("FAIL hold_release gnt=%h busy=%b want 00/0", gnt, busy);
    end
    for (int i = 0; i < 2; i++) begin
      step(8'h00, 1'b1);
      checks++;
      if (dut_out !== 14'h0) begin
        failures++; $display("FAIL stray_done cyc=%0d got=%h want=0000", i, dut_out);
      end
    end
    step(8'hFF, 1'b0);
    checks++;
    if (gnt_idx !== 3'd3) begin
      failures++; $display("FAIL stray_ptr idx=%0d want 3", gnt_idx);
    end
    step(8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       d;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d = ($urandom_range(0, 3) == 0);
      step(r, d);
      checks++;
      if (dut_out !== exp_out()) begin
        failures++; $display("FAIL random cyc=%0d req=%h done=%b got=%h want=%h", i, r, d, dut_out, exp_out());
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_watchdog();
    test_hold_stray();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "simulation time limit");
  end

endmodule
